dllp_receive: RTL and testbench
===============================

DLLP_RECEIVE -- requirements
Module: dllp_receive

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXIS data width; only 32 is supported, and any other value SHALL fail elaboration.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-003 SHALL have parameter USER_WIDTH, default 5, sideband width; bit 0 is the upstream error flag.
REQ-004 Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  asynchronous active-low reset.
- link_up_i  in  1  link up; low flushes the block.
- s_dllp_axis_tdata  in  DATA_WIDTH  DLLP bytes; byte 0 in [7:0].
- s_dllp_axis_tkeep  in  KEEP_WIDTH  byte valids, contiguous from bit 0.
- s_dllp_axis_tvalid  in  1  beat valid.
- s_dllp_axis_tlast  in  1  last beat of DLLP.
- s_dllp_axis_tuser  in  USER_WIDTH  bit 0 = upstream error.
- s_dllp_axis_tready  out  1  beat accept.
- dllp_type_o  out  8  DLLP byte 0.
- dllp_payload_o  out  24  DLLP bytes 1..3, byte 1 in [23:16].
- dllp_valid_o  out  1  decoded DLLP valid.
- dllp_ready_i  in  1  consumer accept.
- crc_err_o  out  1  one-cycle pulse on CRC mismatch.
- malformed_o  out  1  one-cycle pulse on a framing error or tuser[0] drop.
- crc_err_cnt_o  out  16  saturating CRC error count.
- malformed_cnt_o  out  16  saturating malformed count.

Function
REQ-005 A beat SHALL transfer when s_dllp_axis_tvalid and s_dllp_axis_tready are both high; the output SHALL transfer when dllp_valid_o and dllp_ready_i are both high.
REQ-006 The FSM SHALL have states IDLE, BEAT1, DISCARD and HOLD.
REQ-007 s_dllp_axis_tready SHALL be high in IDLE, BEAT1 and DISCARD, and low in HOLD.
REQ-008 Transitions from IDLE on an accepted beat:
- tkeep=4'hF and tlast=0 -> capture bytes 0..3, go to BEAT1.
- any other tkeep -> malformed, go to DISCARD.
- tlast=1 -> malformed, go to IDLE.
REQ-009 Transitions from BEAT1 on an accepted beat:
- tkeep=4'h3 and tlast=1 -> capture bytes 4..5, run the CRC check.
- tkeep other than 4'h3 with tlast=1 -> malformed, go to IDLE.
- tlast=0 -> malformed, go to DISCARD.
REQ-010 DISCARD SHALL drop beats until one with tlast=1 is accepted, then return to IDLE.
REQ-011 If tuser[0]=1 on any accepted beat of a DLLP, the DLLP SHALL be dropped and counted once as malformed, with no CRC check.
REQ-012 CRC: polynomial 0x100B, seed 16'hFFFF, over bytes 0..3 in order, each byte LSB first, giving C.
REQ-013 The CRC check SHALL pass when byte4 == bitrev8(~C[15:8]) and byte5 == bitrev8(~C[7:0]).
REQ-014 On CRC pass, the FSM SHALL go to HOLD with dllp_valid_o=1 on the cycle after the last beat (latency 1 cycle).
REQ-015 On CRC fail, the FSM SHALL pulse crc_err_o, increment crc_err_cnt_o, emit no output and return to IDLE.
REQ-016 HOLD SHALL keep dllp_type_o and dllp_payload_o stable until the output handshake, then go to IDLE.
REQ-017 The CRC SHALL be computed combinationally from the captured bytes and beat-1 data; no extra pipeline stage is allowed.
REQ-018 Each error SHALL pulse its flag exactly once per DLLP and SHALL increment its counter by 1, saturating at 16'hFFFF with no wrap.
REQ-019 When link_up_i is low, the block SHALL force IDLE, deassert dllp_valid_o (dropping any held DLLP), and hold s_dllp_axis_tready high so beats are sunk.
REQ-020 Counters SHALL NOT be cleared by link_up_i.
REQ-021 If link_up_i falls mid-DLLP, the partial DLLP SHALL be discarded and not counted.

Reset
REQ-022 When rst_ni is low, asynchronously:
- state = IDLE;
- dllp_valid_o, crc_err_o, malformed_o = 0;
- crc_err_cnt_o, malformed_cnt_o = 0;
- dllp_type_o, dllp_payload_o = 0.
REQ-023 s_dllp_axis_tready SHALL be 1 once in IDLE during reset.
REQ-024 Deassertion of rst_ni SHALL be synchronised to the rising edge of clk_i internally.

Verification
REQ-025 Ack DLLP:
- stimulus: beat0 32'h0A_00_00_00 (type 8'h00, AckNak seq 12'h00A), tkeep F; beat1 with golden-model CRC, tkeep 3, tlast.
- response: one cycle later dllp_valid_o=1, dllp_type_o=8'h00, dllp_payload_o=24'h00000A; counters stay 0.
REQ-026 Same DLLP with byte5 bit 0 flipped -> crc_err_o single pulse, crc_err_cnt_o=1, dllp_valid_o stays 0.
REQ-027 Back-to-back valid DLLPs with dllp_ready_i held low 5 cycles:
- tready=0 for those 5 cycles;
- first DLLP held stable;
- second DLLP accepted after the handshake;
- no loss.
REQ-028 Framing errors:
- beat0 tkeep 4'h7 -> malformed_cnt_o=1, beats dropped through tlast;
- three-beat DLLP -> malformed_cnt_o=2;
- the next legal DLLP decodes correctly.
REQ-029 crc_err_cnt_o preloaded to 16'hFFFE, then 3 bad-CRC DLLPs -> count ends at 16'hFFFF.
REQ-030 link_up_i dropped in BEAT1, and separately in HOLD -> partial or held DLLP dropped, dllp_valid_o=0 next cycle, counters unchanged.

Source files
------------

// File: rtl/dllp_receive.sv
// Receives 6-byte DLLPs as two AXI-Stream beats (4 + 2 bytes), checks the 16-bit
// DLLP CRC and presents type/payload on a valid/ready port; framing and CRC errors are pulsed and counted.
module dllp_receive #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  link_up_i,
    input  logic [DATA_WIDTH-1:0] s_dllp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_dllp_axis_tkeep,
    input  logic                  s_dllp_axis_tvalid,
    input  logic                  s_dllp_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_dllp_axis_tuser,
    output logic                  s_dllp_axis_tready,
    output logic [7:0]            dllp_type_o,
    output logic [23:0]           dllp_payload_o,
    output logic                  dllp_valid_o,
    input  logic                  dllp_ready_i,
    output logic                  crc_err_o,
    output logic                  malformed_o,
    output logic [15:0]           crc_err_cnt_o,
    output logic [15:0]           malformed_cnt_o
);

    generate
        if (DATA_WIDTH != 32 || KEEP_WIDTH != 4) begin : g_width_check
            $error("dllp_receive supports only DATA_WIDTH=32 with KEEP_WIDTH=4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BEAT1   = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Reset asserts immediately but releases only on a clock edge.
    logic [1:0] rst_sync_reg;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_reg[1];

    function automatic logic [15:0] crc16_dllp(input logic [31:0] data);
        logic [15:0] crc;
        logic        fb;
        crc = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            fb  = crc[15] ^ data[i];
            crc = {crc[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
        end
        return crc;
    endfunction

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] beat0_reg;
    logic        crc_err_reg;
    logic        malformed_reg;
    logic [15:0] crc_err_cnt_reg;
    logic [15:0] malformed_cnt_reg;

    logic        tready_int;
    logic        valid_int;
    logic        beat_acc;
    logic        capture_en;
    logic        crc_err_set;
    logic        malformed_set;
    logic        keep_full;
    logic        keep_two;
    logic        user_err;
    logic        unused_tuser;
    logic [15:0] crc_c;
    logic [7:0]  exp_byte4;
    logic [7:0]  exp_byte5;
    logic        crc_ok;

    assign beat_acc     = s_dllp_axis_tvalid && tready_int;
    assign keep_full    = (s_dllp_axis_tkeep == {KEEP_WIDTH{1'b1}});
    assign keep_two     = (s_dllp_axis_tkeep == KEEP_WIDTH'(4'h3));
    assign user_err     = s_dllp_axis_tuser[0];
    assign unused_tuser = ^s_dllp_axis_tuser;

    // CRC covers the captured first beat; the check bytes arrive on the current beat.
    assign crc_c = crc16_dllp(beat0_reg);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bitrev
            assign exp_byte4[gi] = ~crc_c[15 - gi];
            assign exp_byte5[gi] = ~crc_c[7 - gi];
        end
    endgenerate

    assign crc_ok = (s_dllp_axis_tdata[7:0] == exp_byte4) &&
                    (s_dllp_axis_tdata[15:8] == exp_byte5);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        capture_en    = 1'b0;
        crc_err_set   = 1'b0;
        malformed_set = 1'b0;
        case (state_reg)
            IDLE: begin
                if (beat_acc) begin
                    if (user_err || s_dllp_axis_tlast || !keep_full) begin
                        malformed_set = 1'b1;
                        state_next    = s_dllp_axis_tlast ? IDLE : DISCARD;
                    end else begin
                        capture_en = 1'b1;
                        state_next = BEAT1;
                    end
                end
            end
            BEAT1: begin
                if (beat_acc) begin
                    if (user_err || !s_dllp_axis_tlast || !keep_two) begin
                        malformed_set = 1'b1;
                        state_next    = s_dllp_axis_tlast ? IDLE : DISCARD;
                    end else if (crc_ok) begin
                        state_next = HOLD;
                    end else begin
                        crc_err_set = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (beat_acc && s_dllp_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (dllp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Link down flushes everything; partial DLLPs leave no trace in the counters.
        if (!link_up_i) begin
            state_next    = IDLE;
            capture_en    = 1'b0;
            crc_err_set   = 1'b0;
            malformed_set = 1'b0;
        end
    end

    always_comb begin
        tready_int = 1'b1;
        valid_int  = 1'b0;
        if (link_up_i && state_reg == HOLD) begin
            tready_int = 1'b0;
            valid_int  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            beat0_reg         <= 32'h0;
            crc_err_reg       <= 1'b0;
            malformed_reg     <= 1'b0;
            crc_err_cnt_reg   <= 16'h0;
            malformed_cnt_reg <= 16'h0;
        end else begin
            crc_err_reg   <= crc_err_set;
            malformed_reg <= malformed_set;
            if (capture_en) begin
                beat0_reg <= s_dllp_axis_tdata;
            end
            if (crc_err_set && crc_err_cnt_reg != 16'hFFFF) begin
                crc_err_cnt_reg <= crc_err_cnt_reg + 16'd1;
            end
            if (malformed_set && malformed_cnt_reg != 16'hFFFF) begin
                malformed_cnt_reg <= malformed_cnt_reg + 16'd1;
            end
        end
    end

    assign s_dllp_axis_tready = tready_int;
    assign dllp_valid_o       = valid_int;
    assign dllp_type_o        = beat0_reg[7:0];
    assign dllp_payload_o     = {beat0_reg[15:8], beat0_reg[23:16], beat0_reg[31:24]};
    assign crc_err_o          = crc_err_reg;
    assign malformed_o        = malformed_reg;
    assign crc_err_cnt_o      = crc_err_cnt_reg;
    assign malformed_cnt_o    = malformed_cnt_reg;

endmodule

// File: tb/tb_dllp_receive.sv
// Bench for dllp_receive: directed scenarios plus a randomized DLLP stream scored
// against a packet-level model of the framing, tuser and CRC rules.
module tb_dllp_receive;

    logic        clk;
    logic        rst_ni;
    logic        link_up_i;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic [4:0]  tuser;
    logic        tready;
    logic [7:0]  dtype;
    logic [23:0] dpayload;
    logic        dvalid;
    logic        dready;
    logic        crc_err;
    logic        malformed;
    logic [15:0] crc_cnt;
    logic [15:0] mal_cnt;

    dllp_receive dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .link_up_i          (link_up_i),
        .s_dllp_axis_tdata  (tdata),
        .s_dllp_axis_tkeep  (tkeep),
        .s_dllp_axis_tvalid (tvalid),
        .s_dllp_axis_tlast  (tlast),
        .s_dllp_axis_tuser  (tuser),
        .s_dllp_axis_tready (tready),
        .dllp_type_o        (dtype),
        .dllp_payload_o     (dpayload),
        .dllp_valid_o       (dvalid),
        .dllp_ready_i       (dready),
        .crc_err_o          (crc_err),
        .malformed_o        (malformed),
        .crc_err_cnt_o      (crc_cnt),
        .malformed_cnt_o    (mal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_crc_cnt = 0;
    int exp_mal_cnt = 0;
    int exp_crc_p = 0;
    int exp_mal_p = 0;
    int obs_crc_p = 0;
    int obs_mal_p = 0;
    int obs_valid_cyc = 0;
    bit rand_ready = 1'b0;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];

    logic [31:0] b_data[3];
    logic [3:0]  b_keep[3];
    logic [4:0]  b_user[3];
    int          b_n;

    // Observer: records delivered DLLPs and error pulses.
    always @(negedge clk) begin
        if (dvalid) obs_valid_cyc++;
        if (dvalid && dready) obs_q.push_back({dtype, dpayload});
        if (crc_err) obs_crc_p++;
        if (malformed) obs_mal_p++;
    end

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    // Reference CRC: bytes 0..3 in order, each byte fed LSB first.
    function automatic logic [15:0] model_crc(input logic [31:0] msg);
        logic [15:0] c;
        logic [7:0]  byt;
        logic        top;
        c = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            byt = msg[8*k +: 8];
            for (int j = 0; j < 8; j++) begin
                top = c[15] ^ byt[j];
                c = c << 1;
                if (top) c = c ^ 16'h100B;
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] good_beat1(input logic [31:0] w0);
        logic [15:0] c;
        c = model_crc(w0);
        return {rev8(~c[7:0]), rev8(~c[15:8])};
    endfunction

    function automatic logic [31:0] pkt_word(input logic [31:0] w0);
        return {w0[7:0], w0[15:8], w0[23:16], w0[31:24]};
    endfunction

    // Packet-level rule: only a clean 4+2 byte DLLP reaches the CRC check.
    function automatic void model_pkt();
        logic good_shape;
        good_shape = (b_n == 2) && (b_keep[0] == 4'hF) && (b_keep[1] == 4'h3)
                     && !b_user[0][0] && !b_user[1][0];
        if (!good_shape) begin
            if (exp_mal_cnt < 65535) exp_mal_cnt++;
            exp_mal_p++;
        end else if (b_data[1][15:0] == good_beat1(b_data[0])) begin
            exp_q.push_back(pkt_word(b_data[0]));
        end else begin
            if (exp_crc_cnt < 65535) exp_crc_cnt++;
            exp_crc_p++;
        end
    endfunction

    function automatic void make_good(input logic [31:0] w0);
        b_n = 2;
        b_data[0] = w0;
        b_keep[0] = 4'hF;
        b_data[1] = {16'($urandom), good_beat1(w0)};
        b_keep[1] = 4'h3;
        for (int i = 0; i < 3; i++) b_user[i] = {4'($urandom), 1'b0};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rand_ready) dready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                             input logic l, input logic [4:0] u);
        int   waited;
        logic acc;
        waited = 0;
        tdata = d; tkeep = k; tlast = l; tuser = u; tvalid = 1'b1;
        while (1) begin
            acc = tready;
            @(posedge clk); #1;
            if (rand_ready) dready = 1'($urandom_range(0, 1));
            if (acc) break;
            waited++;
            if (waited > 50) begin
                checks++; failures++;
                $display("FAIL beat_accept_timeout tready=%0b required=1", tready);
                break;
            end
        end
    endtask

    task automatic send_pkt();
        for (int i = 0; i < b_n; i++) send_beat(b_data[i], b_keep[i], (i == b_n - 1), b_user[i]);
        tvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b1; link_up_i = 1'b1; tvalid = 1'b0; tdata = '0; tkeep = '0;
        tlast = 1'b0; tuser = '0; dready = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (tready !== 1'b1 || dvalid !== 1'b0 || crc_err !== 1'b0 || malformed !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags tready=%0b valid=%0b crc=%0b mal=%0b required 1/0/0/0",
                     tready, dvalid, crc_err, malformed);
        end
        checks++;
        if (crc_cnt !== 16'h0 || mal_cnt !== 16'h0 || dtype !== 8'h0 || dpayload !== 24'h0) begin
            failures++;
            $display("FAIL reset_values crc_cnt=%h mal_cnt=%h type=%h payload=%h required all 0",
                     crc_cnt, mal_cnt, dtype, dpayload);
        end
        wait_cycles(3);
        rst_ni = 1'b1;
        wait_cycles(4);
        $display("test_reset done");
    endtask

    task automatic test_ack();
        dready = 1'b1;
        make_good(32'h0A00_0000);
        model_pkt();
        send_pkt();
        @(negedge clk);
        checks++;
        if (dvalid !== 1'b1) begin
            failures++; $display("FAIL ack_valid got=%0b required=1", dvalid);
        end
        checks++;
        if (dtype !== 8'h00 || dpayload !== 24'h00000A) begin
            failures++; $display("FAIL ack_fields type=%h payload=%h required 00/00000a", dtype, dpayload);
        end
        wait_cycles(3);
        checks++;
        if (crc_cnt !== 16'h0 || mal_cnt !== 16'h0) begin
            failures++; $display("FAIL ack_counters crc=%h mal=%h required 0/0", crc_cnt, mal_cnt);
        end
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            failures++; $display("FAIL ack_delivered count=%0d required=1", obs_q.size());
        end
        obs_q.delete(); exp_q.delete();
        $display("test_ack done");
    endtask

    task automatic test_crc_err();
        int p0, v0;
        p0 = obs_crc_p; v0 = obs_valid_cyc;
        make_good(32'h0A00_0000);
        b_data[1] = b_data[1] ^ 32'h0000_0100;
        model_pkt();
        send_pkt();
        wait_cycles(4);
        checks++;
        if (obs_crc_p - p0 != 1) begin
            failures++; $display("FAIL crc_pulse got=%0d pulses required=1", obs_crc_p - p0);
        end
        checks++;
        if (crc_cnt !== 16'd1 || mal_cnt !== 16'd0) begin
            failures++; $display("FAIL crc_count crc=%h mal=%h required 1/0", crc_cnt, mal_cnt);
        end
        checks++;
        if (obs_valid_cyc != v0 || obs_q.size() != 0) begin
            failures++; $display("FAIL crc_no_output valid_cycles=%0d required=0", obs_valid_cyc - v0);
        end
        $display("test_crc_err done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_word;
        logic [31:0] b0, b1;
        dready = 1'b0;
        make_good($urandom);
        a_word = pkt_word(b_data[0]);
        model_pkt();
        send_pkt();
        make_good($urandom);
        b0 = b_data[0]; b1 = b_data[1];
        model_pkt();
        tdata = b0; tkeep = 4'hF; tlast = 1'b0; tuser = 5'h0; tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (tready !== 1'b0 || dvalid !== 1'b1 || {dtype, dpayload} !== a_word) begin
                failures++;
                $display("FAIL b2b_hold cycle=%0d tready=%0b valid=%0b word=%h required 0/1/%h",
                         i, tready, dvalid, {dtype, dpayload}, a_word);
            end
            @(posedge clk); #1;
        end
        dready = 1'b1;
        send_beat(b0, 4'hF, 1'b0, 5'h0);
        send_beat(b1, 4'h3, 1'b1, 5'h0);
        tvalid = 1'b0;
        wait_cycles(3);
        checks++;
        if (obs_q.size() != 2) begin
            failures++; $display("FAIL b2b_count got=%0d required=2", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL b2b_word idx=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        obs_q.delete(); exp_q.delete();
        $display("test_back_to_back done");
    endtask

    task automatic test_framing();
        int p0;
        p0 = obs_mal_p;
        dready = 1'b1;
        make_good($urandom);
        b_n = 3; b_keep[0] = 4'h7; b_data[2] = $urandom; b_keep[1] = 4'hF; b_keep[2] = 4'h3;
        model_pkt();
        send_pkt();
        wait_cycles(2);
        checks++;
        if (mal_cnt !== 16'd1) begin
            failures++; $display("FAIL framing_keep got=%h required=1", mal_cnt);
        end
        make_good($urandom);
        b_n = 3; b_keep[1] = 4'hF; b_data[2] = $urandom; b_keep[2] = 4'h3;
        model_pkt();
        send_pkt();
        wait_cycles(2);
        checks++;
        if (mal_cnt !== 16'd2 || obs_mal_p - p0 != 2) begin
            failures++; $display("FAIL framing_three got=%h pulses=%0d required 2/2", mal_cnt, obs_mal_p - p0);
        end
        make_good($urandom);
        model_pkt();
        send_pkt();
        wait_cycles(3);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            failures++; $display("FAIL framing_recover count=%0d required=1", obs_q.size());
        end
        obs_q.delete(); exp_q.delete();
        $display("test_framing done");
    endtask

    task automatic test_saturation();
        int p0;
        force dut.crc_err_cnt_reg = 16'hFFFE;
        @(posedge clk); #1;
        release dut.crc_err_cnt_reg;
        exp_crc_cnt = 16'hFFFE;
        checks++;
        if (crc_cnt !== 16'hFFFE) begin
            failures++; $display("FAIL sat_preload got=%h required=fffe", crc_cnt);
        end
        p0 = obs_crc_p;
        for (int n = 0; n < 3; n++) begin
            make_good($urandom);
            b_data[1] = b_data[1] ^ (32'h1 << $urandom_range(0, 15));
            model_pkt();
            send_pkt();
            wait_cycles(2);
            checks++;
            if (crc_cnt !== 16'hFFFF) begin
                failures++; $display("FAIL sat_count pkt=%0d got=%h required=ffff", n, crc_cnt);
            end
        end
        checks++;
        if (obs_crc_p - p0 != 3) begin
            failures++; $display("FAIL sat_pulses got=%0d required=3", obs_crc_p - p0);
        end
        $display("test_saturation done");
    endtask

    task automatic test_link_down();
        int c0, m0;
        c0 = obs_crc_p; m0 = obs_mal_p;
        dready = 1'b1;
        make_good($urandom);
        send_beat(b_data[0], 4'hF, 1'b0, 5'h0);
        link_up_i = 1'b0;
        @(negedge clk);
        checks++;
        if (tready !== 1'b1 || dvalid !== 1'b0) begin
            failures++; $display("FAIL linkdn_beat1 tready=%0b valid=%0b required 1/0", tready, dvalid);
        end
        @(posedge clk); #1;
        send_beat(b_data[1], 4'h3, 1'b1, 5'h0);
        tvalid = 1'b0;
        wait_cycles(1);
        link_up_i = 1'b1;
        dready = 1'b0;
        make_good($urandom);
        send_pkt();
        @(negedge clk);
        checks++;
        if (dvalid !== 1'b1) begin
            failures++; $display("FAIL linkdn_hold_setup valid=%0b required=1", dvalid);
        end
        @(posedge clk); #1;
        link_up_i = 1'b0;
        @(negedge clk);
        checks++;
        if (dvalid !== 1'b0 || tready !== 1'b1) begin
            failures++; $display("FAIL linkdn_hold valid=%0b tready=%0b required 0/1", dvalid, tready);
        end
        @(posedge clk); #1;
        link_up_i = 1'b1;
        dready = 1'b1;
        wait_cycles(3);
        checks++;
        if (obs_q.size() != 0 || dvalid !== 1'b0 || tready !== 1'b1) begin
            failures++; $display("FAIL linkdn_dropped delivered=%0d valid=%0b required 0/0", obs_q.size(), dvalid);
        end
        checks++;
        if (crc_cnt !== 16'(exp_crc_cnt) || mal_cnt !== 16'(exp_mal_cnt)
            || obs_crc_p != c0 || obs_mal_p != m0) begin
            failures++; $display("FAIL linkdn_counters crc=%h mal=%h required %h/%h",
                                 crc_cnt, mal_cnt, 16'(exp_crc_cnt), 16'(exp_mal_cnt));
        end
        obs_q.delete(); exp_q.delete();
        $display("test_link_down done");
    endtask

    task automatic test_random();
        int kind, bi;
        rst_ni = 1'b0;
        wait_cycles(2);
        rst_ni = 1'b1;
        wait_cycles(4);
        obs_q.delete(); exp_q.delete();
        obs_crc_p = 0; obs_mal_p = 0; exp_crc_p = 0; exp_mal_p = 0;
        exp_crc_cnt = 0; exp_mal_cnt = 0;
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 6);
            make_good($urandom);
            case (kind)
                1: b_data[1] = b_data[1] ^ (32'h1 << $urandom_range(0, 15));
                2: b_keep[0] = ($urandom_range(0, 1) != 0) ? 4'h7 : 4'h3;
                3: begin b_n = 3; b_keep[1] = 4'hF; b_data[2] = $urandom; b_keep[2] = 4'h3; end
                4: begin bi = $urandom_range(0, 1); b_user[bi][0] = 1'b1; end
                5: b_n = 1;
                6: b_keep[1] = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h1;
                default: ;
            endcase
            model_pkt();
            send_pkt();
            wait_cycles($urandom_range(0, 2));
        end
        rand_ready = 1'b0;
        dready = 1'b1;
        wait_cycles(6);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rand_count got=%0d required=%0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL rand_word idx=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (crc_cnt !== 16'(exp_crc_cnt) || obs_crc_p != exp_crc_p) begin
            failures++; $display("FAIL rand_crc cnt=%h pulses=%0d required %h/%0d",
                                 crc_cnt, obs_crc_p, 16'(exp_crc_cnt), exp_crc_p);
        end
        checks++;
        if (mal_cnt !== 16'(exp_mal_cnt) || obs_mal_p != exp_mal_p) begin
            failures++; $display("FAIL rand_malformed cnt=%h pulses=%0d required %h/%0d",
                                 mal_cnt, obs_mal_p, 16'(exp_mal_cnt), exp_mal_p);
        end
        $display("test_random done delivered=%0d crc_errs=%0d malformed=%0d",
                 exp_q.size(), exp_crc_p, exp_mal_p);
    endtask

    initial begin
        test_reset();
        test_ack();
        test_crc_err();
        test_back_to_back();
        test_framing();
        test_saturation();
        test_link_down();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t required finish before 500000", $time);
        $fatal(1, "timeout");
    end

endmodule
